// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential signed multiplier, radix-4 Booth recoding,
// one recoded digit per clock. The 2*WIDTH product is delivered as hi/lo halves.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; operands latched on the accept edge
// RUN    | one Booth digit per cycle, WIDTH/2 cycles in total
// DONE   | one cycle; done pulses and the product is already valid
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH+1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic             r_q_m1;
  logic [WIDTH-1:0] r_m;

  logic             w_accept;
  logic             w_last;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [2:0]       w_digit;
  logic [WIDTH+1:0] w_m_ext;
  logic [WIDTH+1:0] w_m2_ext;
  logic [WIDTH+1:0] w_addend;
  logic [WIDTH+1:0] w_a_sum;
  logic [WIDTH+1:0] w_a_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_q_m1_nxt;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_DIGIT);

  // State register
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start outside IDLE is ignored
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode on the next state so busy/done come straight from flops
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      S_RUN:   w_busy_nxt = 1'b1;
      S_DONE: begin
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

  // Registered status outputs
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= w_busy_nxt;
      done <= w_done_nxt;
    end
  end

  // Booth digit recoding and add; A is two bits wider than M so 2M never overflows
  always_comb begin
    w_digit  = {r_q[1], r_q[0], r_q_m1};
    w_m_ext  = {{2{r_m[WIDTH-1]}}, r_m};
    w_m2_ext = {r_m[WIDTH-1], r_m, 1'b0};
    w_addend = '0;
    case (w_digit)
      3'b001, 3'b010: w_addend = w_m_ext;
      3'b011:         w_addend = w_m2_ext;
      3'b100:         w_addend = -w_m2_ext;
      3'b101, 3'b110: w_addend = -w_m_ext;
      default:        w_addend = '0;
    endcase
    w_a_sum    = r_a + w_addend;
    w_a_nxt    = {{2{w_a_sum[WIDTH+1]}}, w_a_sum[WIDTH+1:2]};
    w_q_nxt    = {w_a_sum[1:0], r_q[WIDTH-1:2]};
    w_q_m1_nxt = r_q[1];
  end

  // Datapath registers: latch on accept, shift by two per RUN cycle
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_q    <= '0;
      r_q_m1 <= 1'b0;
      r_m    <= '0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_q    <= multiplier;
      r_q_m1 <= 1'b0;
      r_m    <= multiplicand;
    end else if (r_state == S_RUN) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_a    <= w_a_nxt;
      r_q    <= w_q_nxt;
      r_q_m1 <= w_q_m1_nxt;
    end
  end

  // Product registers load the post-shift value on the final digit and then hold
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      product_hi <= '0;
      product_lo <= '0;
    end else if (w_last) begin
      product_hi <= w_a_nxt[WIDTH-1:0];
      product_lo <= w_q_nxt;
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Testbench for booth_mul_seq: directed corner cases plus random operands,
// checked against a plain signed 64-bit multiply.
module tb_booth_mul_seq;

  logic        Clock;
  logic        clear;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  booth_mul_seq #(.WIDTH(32)) dut (
    .Clock        (Clock),
    .clear        (clear),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product_hi   (product_hi),
    .product_lo   (product_lo)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) if (done) n_done++;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for done; returns edges counted after the accept edge
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge Clock); #1;
      lat++;
      if (done) break;
    end
  endtask

  // One full operation starting from IDLE; done is expected in the cycle after edge 16
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int lat;
    exp = model(a, b);
    @(negedge Clock);
    multiplicand = a; multiplier = b; start = 1'b1;
    @(posedge Clock); #1;
    chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
    @(negedge Clock);
    start = 1'b0;
    multiplicand = $urandom; multiplier = $urandom;
    wait_done(lat);
    chk({tag, "_latency"}, 64'(lat), 64'd16);
    chk({tag, "_product"}, {product_hi, product_lo}, exp);
    @(posedge Clock); #1;
    chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
    chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] prev;
    int lat;
    int d0;
    logic [31:0] ra;
    logic [31:0] rb;

    clear = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", {product_hi, product_lo}, 64'd0);
    @(negedge Clock); clear = 1'b1;

    do_op("basic", 32'hFFFFFFFF, 32'hF0000014);
    chk("basic_const", {product_hi, product_lo}, 64'h00000000_0FFFFFEC);

    // Reset in the middle of RUN
    @(negedge Clock);
    multiplicand = 32'd7; multiplier = 32'd5; start = 1'b1;
    @(posedge Clock);
    @(negedge Clock); start = 1'b0;
    repeat (8) @(posedge Clock);
    #1; clear = 1'b0; #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_product", {product_hi, product_lo}, 64'd0);
    d0 = n_done;
    repeat (20) @(posedge Clock);
    #1;
    chk("midrst_no_done", 64'(n_done - d0), 64'd0);
    @(negedge Clock); clear = 1'b1;
    do_op("after_rst", 32'd7, 32'd5);
    chk("after_rst_const", {product_hi, product_lo}, 64'h00000000_00000023);

    do_op("minmin", 32'h80000000, 32'h80000000);
    chk("minmin_const", {product_hi, product_lo}, 64'h40000000_00000000);
    do_op("maxmax", 32'h7FFFFFFF, 32'h7FFFFFFF);
    chk("maxmax_const", {product_hi, product_lo}, 64'h3FFFFFFF_00000001);
    do_op("minmax", 32'h80000000, 32'h7FFFFFFF);
    chk("minmax_const", {product_hi, product_lo}, 64'hC0000000_80000000);
    do_op("neg3", 32'd7, 32'hFFFFFFFD);
    chk("neg3_const", {product_hi, product_lo}, 64'hFFFFFFFF_FFFFFFEB);
    do_op("zero", 32'd0, 32'h12345678);

    // start held high through RUN/DONE: new operands ignored until back in IDLE
    prev = {product_hi, product_lo};
    d0 = n_done;
    @(negedge Clock);
    multiplicand = 32'd3; multiplier = 32'd4; start = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    multiplicand = 32'd9; multiplier = 32'd9;
    repeat (8) @(posedge Clock);
    #1;
    chk("bp_hold_midrun", {product_hi, product_lo}, prev);
    lat = 0;
    while (lat < 40) begin
      @(posedge Clock); #1;
      lat++;
      if (done) break;
    end
    chk("bp_latency1", 64'(lat + 8), 64'd16);
    chk("bp_product1", {product_hi, product_lo}, 64'h00000000_0000000C);
    @(posedge Clock); #1;
    chk("bp_idle_gap", 64'(busy), 64'd0);
    @(posedge Clock); #1;
    chk("bp_reaccept", 64'(busy), 64'd1);
    @(negedge Clock); start = 1'b0;
    wait_done(lat);
    chk("bp_latency2", 64'(lat), 64'd16);
    chk("bp_product2", {product_hi, product_lo}, 64'h00000000_00000051);
    @(posedge Clock); #1;
    chk("bp_done_count", 64'(n_done - d0), 64'd2);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra = 32'($signed(-int'($urandom_range(0, 100))));
      do_op("rand", ra, rb);
    end

    // Hold: operand changes without start leave everything untouched
    prev = {product_hi, product_lo};
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      multiplicand = $urandom; multiplier = $urandom;
      @(posedge Clock); #1;
      if (busy !== 1'b0 || i == 29) chk("hold_busy", 64'(busy), 64'd0);
    end
    chk("hold_product", {product_hi, product_lo}, prev);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
